// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Imported by the fetch stage, its skid buffer and the bench.
package fetch_stage_pkg;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUF_FULL = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_t;

    // Instructions are halfword aligned; bit 0 of a target is dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port between the fetch stage (master) and instruction memory (slave).
// Handshake: imem_en requests a read of imem_addr; imem_done=1 in the same cycle means imem_rdata is the word at imem_addr.
interface fetch_stage_if;

    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  imem_done
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output imem_done
    );

endinterface

// File: rtl/fetch_buf.sv
// One-entry skid buffer that catches a fetched word while decode is stalled.
// Clear wins over load so a flush never leaves a stale entry behind.
module fetch_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc_inc,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr  <= NOP_INSTR;
            pc_inc <= RESET_PC;
            full   <= 1'b0;
        end else if (clear) begin
            full   <= 1'b0;
        end else if (load) begin
            instr  <= load_instr;
            pc_inc <= load_pc_inc;
            full   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID pipeline register.
// A word returned during a decode stall is parked in fetch_buf and replayed on release.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    input  logic                halt_req,
    output logic [15:0]         if_instr,
    output logic [15:0]         if_pc_inc,
    output logic                if_valid,
    output logic                halted,
    output logic                fetch_err,
    output fetch_state_t        state_dbg
);

    fetch_state_t state, state_d;
    logic [15:0]  pc, pc_d, pc_plus2;
    logic [15:0]  instr_d, pc_inc_d;
    logic         valid_d, err_d;
    logic         buf_load, buf_clear, buf_full;
    logic [15:0]  buf_instr, buf_pc_inc;

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .clear       (buf_clear),
        .load_instr  (imem.imem_rdata),
        .load_pc_inc (pc_plus2),
        .instr       (buf_instr),
        .pc_inc      (buf_pc_inc),
        .full        (buf_full)
    );

    assign pc_plus2       = pc + 16'd2;
    assign imem.imem_en   = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign halted         = (state == ST_HALTED);
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            if_instr  <= NOP_INSTR;
            if_pc_inc <= RESET_PC;
            if_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            if_instr  <= instr_d;
            if_pc_inc <= pc_inc_d;
            if_valid  <= valid_d;
            fetch_err <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        instr_d   = if_instr;
        pc_inc_d  = if_pc_inc;
        valid_d   = if_valid;
        err_d     = fetch_err;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state)
            ST_FETCH, ST_BUF_FULL: begin
                // Redirect beats halt, stall and memory status; a bubble keeps the old pc_inc.
                if (redirect) begin
                    pc_d      = align_pc(redirect_pc);
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                    if (redirect_pc[0]) err_d = 1'b1;
                end else if (halt_req) begin
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                    state_d   = ST_HALTED;
                end else if (state == ST_FETCH) begin
                    if (imem.imem_done) begin
                        pc_d = pc_plus2;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_d  = ST_BUF_FULL;
                        end else begin
                            instr_d  = imem.imem_rdata;
                            pc_inc_d = pc_plus2;
                            valid_d  = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (!stall && buf_full) begin
                    instr_d   = buf_instr;
                    pc_inc_d  = buf_pc_inc;
                    valid_d   = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALTED: begin
            end
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a hashed instruction memory, an expected-IF/ID queue
// filled when a fetch is accepted and drained when the word should appear in IF/ID.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [15:0]  redirect_pc = 16'h0000;
    logic         halt_req = 1'b0;
    logic         done = 1'b1;
    logic [15:0]  if_instr, if_pc_inc;
    logic         if_valid, halted, fetch_err;
    fetch_state_t state_dbg;

    logic [15:0]  mem_key;
    logic [31:0]  exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .if_instr    (if_instr),
        .if_pc_inc   (if_pc_inc),
        .if_valid    (if_valid),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Odd multiplier makes every address map to a distinct word.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ mem_key;
    endfunction

    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
    assign imem_bus.imem_done  = done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [15:0] addr);
        exp_q.push_back({mem_word(addr), addr + 16'd2});
    endtask

    task automatic chk_ifid(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, {16'd0, if_instr}, {16'd0, e[31:16]});
            chk({tag, "_pcinc"}, {16'd0, if_pc_inc}, {16'd0, e[15:0]});
            chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_instr"}, {16'd0, if_instr}, {16'd0, NOP_INSTR});
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    endtask

    task automatic chk_addr(input string tag, input logic [15:0] exp);
        chk(tag, {16'd0, imem_bus.imem_addr}, {16'd0, exp});
    endtask

    initial begin
        mem_key = 16'($urandom_range(0, 16'hFFFF));

        // Reset values while rst is held, including over a fetch-done input.
        tick();
        tick();
        chk_addr("rst_pc", 16'h0000);
        chk_bubble("rst_ifid");
        chk("rst_pcinc", {16'd0, if_pc_inc}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_FETCH));

        // Streaming fetch, one word per cycle.
        rst = 1'b0;
        chk("first_en", {31'd0, imem_bus.imem_en}, 32'd1);
        push_fetch(16'h0000);
        tick();
        chk_addr("stream_addr2", 16'h0002);
        chk_ifid("stream0");
        push_fetch(16'h0002);
        tick();
        chk_addr("stream_addr4", 16'h0004);
        chk_ifid("stream2");

        // Stall three cycles at PC=4: word@4 parks in the buffer.
        stall = 1'b1;
        push_fetch(16'h0004);
        tick();
        chk("stall_state", 32'(state_dbg), 32'(ST_BUF_FULL));
        chk("stall_en", {31'd0, imem_bus.imem_en}, 32'd0);
        chk("stall_hold_instr", {16'd0, if_instr}, {16'd0, mem_word(16'h0002)});
        tick();
        tick();
        chk("stall_hold_pcinc", {16'd0, if_pc_inc}, 32'h0004);
        chk("stall_hold_valid", {31'd0, if_valid}, 32'd1);
        chk_addr("stall_addr", 16'h0006);
        stall = 1'b0;
        tick();
        chk_ifid("release4");
        chk("release_state", 32'(state_dbg), 32'(ST_FETCH));
        chk_addr("release_addr", 16'h0006);

        // Fill the buffer, then redirect under stall: buffer must be dropped.
        stall = 1'b1;
        tick();
        chk("fill_state", 32'(state_dbg), 32'(ST_BUF_FULL));
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        chk_bubble("redir_ifid");
        chk_addr("redir_addr", 16'h0040);
        chk("redir_state", 32'(state_dbg), 32'(ST_FETCH));
        redirect = 1'b0;
        stall = 1'b0;
        push_fetch(16'h0040);
        tick();
        chk_ifid("after_redir");

        // Memory not done for two cycles: bubbles and a held PC.
        done = 1'b0;
        tick();
        chk_bubble("wait1");
        chk_addr("wait1_addr", 16'h0042);
        tick();
        chk_bubble("wait2");
        chk_addr("wait2_addr", 16'h0042);
        done = 1'b1;
        push_fetch(16'h0042);
        tick();
        chk_ifid("wait_done");
        chk_addr("wait_done_addr", 16'h0044);

        // Misaligned redirect sets the sticky error; wrap past 16'hFFFE.
        redirect = 1'b1;
        redirect_pc = 16'h0033;
        tick();
        chk_addr("mis_addr", 16'h0032);
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        redirect = 1'b0;
        push_fetch(16'h0032);
        tick();
        chk_ifid("mis_fetch");
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        chk_addr("wrap_addr", 16'hFFFE);
        redirect = 1'b0;
        push_fetch(16'hFFFE);
        tick();
        chk_ifid("wrap_fffe");
        chk_addr("wrap_addr0", 16'h0000);
        push_fetch(16'h0000);
        tick();
        chk_ifid("wrap_0");
        chk("sticky_err", {31'd0, fetch_err}, 32'd1);

        // Halt at PC=8; later redirects, stalls and halts are ignored.
        redirect = 1'b1;
        redirect_pc = 16'h0008;
        tick();
        redirect = 1'b0;
        halt_req = 1'b1;
        tick();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_en", {31'd0, imem_bus.imem_en}, 32'd0);
        chk_addr("halt_addr", 16'h0008);
        chk_bubble("halt_ifid");
        halt_req = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        chk_addr("halt_frozen_addr", 16'h0008);
        chk("halt_frozen_flag", {31'd0, halted}, 32'd1);
        chk_bubble("halt_frozen_ifid");
        redirect = 1'b0;
        stall = 1'b0;
        rst = 1'b1;
        tick();
        chk_addr("halt_rst_addr", 16'h0000);
        chk("halt_rst_flag", {31'd0, halted}, 32'd0);
        chk("halt_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("halt_rst_state", 32'(state_dbg), 32'(ST_FETCH));

        // Reset while the buffer holds a word.
        rst = 1'b0;
        push_fetch(16'h0000);
        tick();
        chk_ifid("post_rst");
        stall = 1'b1;
        tick();
        chk("mid_stall_state", 32'(state_dbg), 32'(ST_BUF_FULL));
        rst = 1'b1;
        tick();
        chk("mid_rst_state", 32'(state_dbg), 32'(ST_FETCH));
        chk_bubble("mid_rst_ifid");
        chk_addr("mid_rst_addr", 16'h0000);
        rst = 1'b0;
        stall = 1'b0;
        push_fetch(16'h0000);
        tick();
        chk_ifid("mid_rst_refetch");
        chk_addr("mid_rst_next", 16'h0002);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hazard hold from decode; IF/ID register and PC hold.
REQ-005 redirect  input  1  taken branch/jump from a later stage; flush and reload PC.
REQ-006 redirect_pc  input  16  target address for redirect.
REQ-007 halt_req  input  1  decode holds a valid HALT; stop fetching.
REQ-008 imem_rdata  input  16  instruction word from instruction memory.
REQ-009 imem_done  input  1  imem_rdata valid for the current imem_addr this cycle.
REQ-010 imem_en  output  1  instruction memory access request.
REQ-011 imem_addr  output  16  fetch address (current PC).
REQ-012 if_instr  output  16  IF/ID instruction; bits [15:11] drive the decode control opcode.
REQ-013 if_pc_inc  output  16  IF/ID PC+2 of if_instr, used for link and branch targets.
REQ-014 if_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 halted  output  1  fetch permanently stopped until reset.
REQ-016 fetch_err  output  1  sticky flag: misaligned redirect target seen.

Function
REQ-017 SHALL implement states FETCH, BUF_FULL, HALTED.
REQ-018 FETCH: imem_en=1, imem_addr=PC.
REQ-019 FETCH, imem_done=1, stall=0: IF/ID <= {imem_rdata, PC+2, valid 1}; PC <= PC+2.
REQ-020 FETCH, imem_done=1, stall=1: skid buffer <= {imem_rdata, PC+2}; PC <= PC+2; IF/ID holds; next state BUF_FULL.
REQ-021 FETCH, imem_done=0, stall=0: IF/ID <= bubble (instr 16'h0800 NOP, valid 0); PC holds.
REQ-022 FETCH, imem_done=0, stall=1: IF/ID and PC hold.
REQ-023 BUF_FULL: imem_en=0; IF/ID holds while stall=1; when stall=0, IF/ID <= buffer with valid 1 and next state is FETCH.
REQ-024 redirect=1 in FETCH or BUF_FULL: PC <= {redirect_pc[15:1],1'b0}; IF/ID <= bubble; buffer discarded; next state FETCH; overrides stall, imem_done and halt_req.
REQ-025 redirect with redirect_pc[0]=1 SHALL set fetch_err.
REQ-026 halt_req=1 with redirect=0, in FETCH or BUF_FULL: next state HALTED; PC holds; IF/ID <= bubble; buffer discarded; overrides stall.
REQ-027 HALTED: imem_en=0, halted=1, PC and IF/ID frozen; redirect, stall, halt_req ignored; exit only by rst.
REQ-028 PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, no error.
REQ-029 if_pc_inc SHALL always equal the fetch address of if_instr plus 2 (modulo 2^16).
REQ-030 With imem_done tied 1 and no stall, one instruction enters IF/ID per cycle; fetch latency 1 cycle.

Reset
REQ-031 rst SHALL give PC=16'h0000, state FETCH, IF/ID instr=16'h0800, if_pc_inc=16'h0000, if_valid=0, buffer empty, halted=0, fetch_err=0.
REQ-032 rst SHALL take priority over all inputs in any state, including mid-stall and HALTED.
REQ-033 imem_en SHALL be 1 in the first cycle after reset is released.

Structure
REQ-034 Shared package SHALL hold RESET_PC (16'h0000), NOP_INSTR (16'h0800), and the fetch state encoding.
REQ-035 The skid buffer (instruction, pc_inc, full flag) SHALL be a sub-module named fetch_buf; PC register, FSM and IF/ID register stay in fetch_stage.

Verification
REQ-036 Reset, imem_done=1, 4 cycles: imem_addr 0,2,4,6; if_pc_inc 2,4,6; if_valid=1 from cycle 2.
REQ-037 stall=1 for 3 cycles while done=1 at PC=4: state BUF_FULL, imem_en=0, IF/ID unchanged; on release IF/ID = word@4, if_pc_inc=6, next addr 6.
REQ-038 redirect=1, redirect_pc=16'h0040, with stall=1 and buffer full: next IF/ID bubble (if_valid=0), imem_addr=16'h0040, buffer empty.
REQ-039 halt_req=1 at PC=8: halted=1, imem_en=0, IF/ID bubble; later redirect to 16'h0100 ignored; rst returns PC to 0.
REQ-040 redirect_pc=16'h0033: imem_addr=16'h0032, fetch_err=1 and stays 1 until rst; redirect to 16'hFFFE then 2 fetches gives addr 16'h0000.
REQ-041 imem_done=0 for 2 cycles, stall=0: two bubbles with if_valid=0, imem_addr held; done=1 gives valid instruction, PC+2.
